adder_rr_arbiter: RTL and testbench

- Shares one n_bit_adder instance among NREQ requesters using round-robin arbitration and a valid/ready handshake on each side.
- Grants at most one requester per cycle and captures the adder result in a single-entry output register, tagged with the requester index.
- Sits between multiple datapath clients and a single adder resource.

---
 rtl/adder_rr_arbiter.sv | 109 ++++++++++
 tb/tb_adder_rr_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: round-robin sharing of one n_bit_adder among NREQ valid/ready requesters.
// Define ADDARB_SAT_EN to saturate rsp_sum to the signed extreme on signed overflow.

module n_bit_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         co
);
    assign {co, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
endmodule

module adder_rr_arbiter #(
    parameter int N    = 8,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_sum,
    output logic              rsp_co,
    output logic              rsp_ovf
);
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] g;
    logic           found;
    logic           accept;
    logic           xfer;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [N-1:0]   sum;
    logic [N-1:0]   res;
    logic           co;
    logic           ovf;

    function automatic logic [IDW-1:0] wrap(input int v);
        return IDW'(v % NREQ);
    endfunction

    // Scan downward so the candidate closest to ptr is the one left in g.
    always_comb begin
        g = '0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[wrap(int'(ptr) + k)]) begin
                g = wrap(int'(ptr) + k);
                found = 1'b1;
            end
        end
    end

    assign accept = !rsp_valid || rsp_ready;
    assign xfer   = found && accept;

    always_comb begin
        req_ready = '0;
        req_ready[g] = xfer;
    end

    assign a = req_a[int'(g)*N +: N];
    assign b = req_b[int'(g)*N +: N];

    n_bit_adder #(.N(N)) u_add (
        .a   (a),
        .b   (b),
        .cin (req_cin[g]),
        .sum (sum),
        .co  (co)
    );

    assign ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);

`ifdef ADDARB_SAT_EN
    assign res = !ovf ? sum : a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`else
    assign res = sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_co    <= 1'b0;
            rsp_ovf   <= 1'b0;
            ptr       <= '0;
        end else if (xfer) begin
            rsp_valid <= 1'b1;
            rsp_id    <= g;
            rsp_sum   <= res;
            rsp_co    <= co;
            rsp_ovf   <= ovf;
            ptr       <= wrap(int'(g) + 1);
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// tb_adder_rr_arbiter: directed self-checking bench for adder_rr_arbiter (N=8, NREQ=4).
module tb_adder_rr_arbiter;
    localparam int N = 8;
    localparam int NREQ = 4;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a = '0;
    logic [NREQ*N-1:0] req_b = '0;
    logic [NREQ-1:0]   req_cin = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_sum;
    logic              rsp_co;
    logic              rsp_ovf;

    int tests = 0;
    int fails = 0;

    adder_rr_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_co    (rsp_co),
        .rsp_ovf   (rsp_ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = '0;
        rsp_ready = 1'b0;
        do_reset();
        #1;
        tests++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_co, rsp_ovf} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b id=%0d sum=%h co=%b ovf=%b, want all 0",
                     rsp_valid, rsp_id, rsp_sum, rsp_co, rsp_ovf);
        end
        tests++;
        if (req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
    endtask

    task automatic test_single();
        req_valid = 4'b0100;
        req_a[2*N +: N] = 8'd5;
        req_b[2*N +: N] = 8'd10;
        req_cin = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        tests++;
        if (req_ready !== 4'b0100) begin
            fails++;
            $display("FAIL single_grant: got %b want 0100", req_ready);
        end
        step();
        req_valid = '0;
        req_cin = '0;
        tests++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_co, rsp_ovf} !== {1'b1, 2'd2, 8'd16, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL single_rsp: got v=%b id=%0d sum=%0d co=%b ovf=%b, want v=1 id=2 sum=16 co=0 ovf=0",
                     rsp_valid, rsp_id, rsp_sum, rsp_co, rsp_ovf);
        end
        step();
        tests++;
        if (rsp_valid !== 1'b0 || rsp_sum !== 8'd16) begin
            fails++;
            $display("FAIL single_drain: got v=%b sum=%0d, want v=0 sum=16", rsp_valid, rsp_sum);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*N +: N] = 8'(i * 10);
            req_b[i*N +: N] = 8'd1;
        end
        req_cin = '0;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1;
            tests++;
            if (req_ready !== 4'(1 << (c % 4))) begin
                fails++;
                $display("FAIL rr_grant%0d: got %b want %b", c, req_ready, 4'(1 << (c % 4)));
            end
            step();
            tests++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(c % 4) || rsp_sum !== 8'((c % 4) * 10 + 1)) begin
                fails++;
                $display("FAIL rr_rsp%0d: got v=%b id=%0d sum=%0d, want v=1 id=%0d sum=%0d",
                         c, rsp_valid, rsp_id, rsp_sum, c % 4, (c % 4) * 10 + 1);
            end
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_backpressure();
        // ptr is 1 after the round-robin sequence
        req_a[1*N +: N] = 8'd20;
        req_b[1*N +: N] = 8'd3;
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1;
        tests++;
        if (req_ready !== 4'b0010) begin
            fails++;
            $display("FAIL bp_first_grant: got %b want 0010", req_ready);
        end
        step();
        req_a[0*N +: N] = 8'd1;
        req_b[0*N +: N] = 8'd2;
        req_a[3*N +: N] = 8'd7;
        req_b[3*N +: N] = 8'd8;
        req_valid = 4'b1001;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (req_ready !== 4'b0000) begin
                fails++;
                $display("FAIL bp_stall_ready%0d: got %b want 0000", c, req_ready);
            end
            step();
            tests++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 8'd23) begin
                fails++;
                $display("FAIL bp_hold%0d: got v=%b id=%0d sum=%0d, want v=1 id=1 sum=23",
                         c, rsp_valid, rsp_id, rsp_sum);
            end
        end
        rsp_ready = 1'b1;
        #1;
        tests++;
        if (req_ready !== 4'b1000) begin
            fails++;
            $display("FAIL bp_release_grant: got %b want 1000", req_ready);
        end
        step();
        tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sum !== 8'd15) begin
            fails++;
            $display("FAIL bp_reload: got v=%b id=%0d sum=%0d, want v=1 id=3 sum=15",
                     rsp_valid, rsp_id, rsp_sum);
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_overflow();
        logic [N-1:0] exp_pos;
        logic [N-1:0] exp_neg;
`ifdef ADDARB_SAT_EN
        exp_pos = 8'h7F;
        exp_neg = 8'h80;
`else
        exp_pos = 8'h80;
        exp_neg = 8'h7F;
`endif
        do_reset();
        rsp_ready = 1'b1;
        req_cin = '0;
        req_a[0*N +: N] = 8'd127;
        req_b[0*N +: N] = 8'd1;
        req_valid = 4'b0001;
        step();
        tests++;
        if ({rsp_valid, rsp_sum, rsp_co, rsp_ovf} !== {1'b1, exp_pos, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL ovf_pos: got v=%b sum=%h co=%b ovf=%b, want v=1 sum=%h co=0 ovf=1",
                     rsp_valid, rsp_sum, rsp_co, rsp_ovf, exp_pos);
        end
        req_a[0*N +: N] = 8'h80;
        req_b[0*N +: N] = 8'hFF;
        step();
        tests++;
        if ({rsp_valid, rsp_sum, rsp_co, rsp_ovf} !== {1'b1, exp_neg, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL ovf_neg: got v=%b sum=%h co=%b ovf=%b, want v=1 sum=%h co=1 ovf=1",
                     rsp_valid, rsp_sum, rsp_co, rsp_ovf, exp_neg);
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_a[2*N +: N] = 8'd9;
        req_b[2*N +: N] = 8'd9;
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        step();
        tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin
            fails++;
            $display("FAIL rmid_setup: got v=%b id=%0d, want v=1 id=2", rsp_valid, rsp_id);
        end
        // ptr is 3 here; from 3 the next grant would be 3, from 0 it is 1
        req_a[1*N +: N] = 8'd4;
        req_b[1*N +: N] = 8'd4;
        req_valid = 4'b1010;
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_co, rsp_ovf} !== '0) begin
            fails++;
            $display("FAIL rmid_clear: got v=%b id=%0d sum=%h co=%b ovf=%b, want all 0",
                     rsp_valid, rsp_id, rsp_sum, rsp_co, rsp_ovf);
        end
        #1;
        tests++;
        if (req_ready !== 4'b0010) begin
            fails++;
            $display("FAIL rmid_grant: got %b want 0010", req_ready);
        end
        step();
        tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 8'd8) begin
            fails++;
            $display("FAIL rmid_rsp: got v=%b id=%0d sum=%0d, want v=1 id=1 sum=8", rsp_valid, rsp_id, rsp_sum);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
    endtask

    task automatic test_idle_gap();
        do_reset();
        rsp_ready = 1'b1;
        req_a[0*N +: N] = 8'd2;
        req_b[0*N +: N] = 8'd3;
        req_a[3*N +: N] = 8'd6;
        req_b[3*N +: N] = 8'd6;
        req_valid = 4'b1000;
        #1;
        tests++;
        if (req_ready !== 4'b1000) begin
            fails++;
            $display("FAIL gap_first_grant: got %b want 1000", req_ready);
        end
        step();
        tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sum !== 8'd12) begin
            fails++;
            $display("FAIL gap_first_rsp: got v=%b id=%0d sum=%0d, want v=1 id=3 sum=12", rsp_valid, rsp_id, rsp_sum);
        end
        req_valid = '0;
        for (int c = 0; c < 2; c++) begin
            #1;
            tests++;
            if (req_ready !== 4'b0000) begin
                fails++;
                $display("FAIL gap_idle_ready%0d: got %b want 0000", c, req_ready);
            end
            step();
        end
        tests++;
        if (rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL gap_idle_valid: got %b want 0", rsp_valid);
        end
        req_valid = 4'b1001;
        #1;
        tests++;
        if (req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL gap_second_grant: got %b want 0001", req_ready);
        end
        step();
        tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 8'd5) begin
            fails++;
            $display("FAIL gap_second_rsp: got v=%b id=%0d sum=%0d, want v=1 id=0 sum=5", rsp_valid, rsp_id, rsp_sum);
        end
        req_valid = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_idle_gap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
